// File: rtl/ysyx_23060075_lsu_pkg.sv
// Shared constants for the load/store unit: FSM encodings, mask/funct3 widths
// and the load funct3 codes used by the extension logic.
package ysyx_23060075_lsu_pkg;

  localparam int unsigned LSU_STATE_WIDTH = 2;
  localparam int unsigned MEM_MASK_WIDTH  = 4;
  localparam int unsigned FUNCT3_WIDTH    = 3;

  localparam logic [LSU_STATE_WIDTH-1:0] LSU_IDLE = 2'd0;
  localparam logic [LSU_STATE_WIDTH-1:0] LSU_REQ  = 2'd1;
  localparam logic [LSU_STATE_WIDTH-1:0] LSU_WAIT = 2'd2;
  localparam logic [LSU_STATE_WIDTH-1:0] LSU_DONE = 2'd3;

  localparam logic [FUNCT3_WIDTH-1:0] F3_LB  = 3'b000;
  localparam logic [FUNCT3_WIDTH-1:0] F3_LH  = 3'b001;
  localparam logic [FUNCT3_WIDTH-1:0] F3_LW  = 3'b010;
  localparam logic [FUNCT3_WIDTH-1:0] F3_LBU = 3'b100;
  localparam logic [FUNCT3_WIDTH-1:0] F3_LHU = 3'b101;

endpackage

// File: rtl/ysyx_23060075_lsu_align.sv
// Combinational byte-lane steering for the LSU (4 lanes of 8 bits).
//   mask_i/off_i/wdata_i -> wstrb_o/wdata_o : store strobes and lane-shifted data
//   rsp_data_i/funct3_i  -> load_data_o     : load shift plus sign/zero extension
// Strobe bits shifted past lane 3 are dropped; load bytes past lane 3 read as 0.
module ysyx_23060075_lsu_align
  import ysyx_23060075_lsu_pkg::*;
(
  input  logic [MEM_MASK_WIDTH-1:0] mask_i,
  input  logic [1:0]                off_i,
  input  logic [FUNCT3_WIDTH-1:0]   funct3_i,
  input  logic [31:0]               wdata_i,
  input  logic [31:0]               rsp_data_i,
  output logic [3:0]                wstrb_o,
  output logic [31:0]               wdata_o,
  output logic [31:0]               load_data_o
);

  logic [31:0] sh;

  always_comb begin
    wstrb_o = mask_i << off_i;
    wdata_o = wdata_i << {off_i, 3'b000};
    sh      = rsp_data_i >> {off_i, 3'b000};
    case (funct3_i)
      F3_LB:   load_data_o = {{24{sh[7]}}, sh[7:0]};
      F3_LH:   load_data_o = {{16{sh[15]}}, sh[15:0]};
      F3_LW:   load_data_o = sh;
      F3_LBU:  load_data_o = {24'd0, sh[7:0]};
      F3_LHU:  load_data_o = {16'd0, sh[15:0]};
      default: load_data_o = sh;
    endcase
  end

endmodule

// File: rtl/ysyx_23060075_lsu.sv
// Load/store unit: accepts one request (valid/ready), runs one word-aligned
// data-memory bus transaction and returns extended load data (valid/ready).
//   in_*  : request from the decoder/ALU (enables, mask, funct3, addr, wdata)
//   bus_* : request (valid/ready, addr, we, wstrb, wdata) and response channel
//   out_* : result to writeback (rdata, err)
// Optional: define YSYX_23060075_LSU_ALIGN_CHECK_EN to reject misaligned
// accesses without touching the bus (result err=1, rdata=0).
module ysyx_23060075_lsu
  import ysyx_23060075_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_mem_r_en,
  input  logic                      in_mem_w_en,
  input  logic [MEM_MASK_WIDTH-1:0] in_mem_mask,
  input  logic [FUNCT3_WIDTH-1:0]   in_funct3,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic [DATA_W-1:0]         in_wdata,
  output logic                      bus_req_valid,
  input  logic                      bus_req_ready,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic                      bus_we,
  output logic [3:0]                bus_wstrb,
  output logic [DATA_W-1:0]         bus_wdata,
  input  logic                      bus_rsp_valid,
  input  logic [DATA_W-1:0]         bus_rsp_data,
  input  logic                      bus_rsp_err,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_rdata,
  output logic                      out_err
);

  logic [LSU_STATE_WIDTH-1:0] state_q, state_d;
  logic                       load_q, store_q;
  logic [MEM_MASK_WIDTH-1:0]  mask_q;
  logic [FUNCT3_WIDTH-1:0]    funct3_q;
  logic [ADDR_W-1:0]          addr_q;
  logic [DATA_W-1:0]          wdata_q;
  logic [DATA_W-1:0]          rdata_q, rdata_d;
  logic                       err_q, err_d;

  logic        accept, is_mem, misaligned;
  logic [3:0]  strb_sh;
  logic [31:0] wdata_sh, load_data;

  assign accept = in_valid & (state_q == LSU_IDLE);
  assign is_mem = in_mem_r_en | in_mem_w_en;

`ifdef YSYX_23060075_LSU_ALIGN_CHECK_EN
  assign misaligned = is_mem & (((in_mem_mask == 4'b1111) & (in_addr[1:0] != 2'b00)) |
                                ((in_mem_mask == 4'b0011) & in_addr[0]));
`else
  assign misaligned = 1'b0;
`endif

  ysyx_23060075_lsu_align u_align (
    .mask_i      (mask_q),
    .off_i       (addr_q[1:0]),
    .funct3_i    (funct3_q),
    .wdata_i     (wdata_q),
    .rsp_data_i  (bus_rsp_data),
    .wstrb_o     (strb_sh),
    .wdata_o     (wdata_sh),
    .load_data_o (load_data)
  );

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      LSU_IDLE: begin
        if (accept) begin
          // Clearing here gives non-memory requests and stores a zero result.
          rdata_d = '0;
          err_d   = 1'b0;
          if (!is_mem) begin
            state_d = LSU_DONE;
          end else if (misaligned) begin
            state_d = LSU_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = LSU_REQ;
          end
        end
      end
      LSU_REQ:  if (bus_req_ready) state_d = LSU_WAIT;
      LSU_WAIT: begin
        if (bus_rsp_valid) begin
          state_d = LSU_DONE;
          err_d   = bus_rsp_err;
          rdata_d = load_q ? load_data : '0;
        end
      end
      LSU_DONE: if (out_ready) state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LSU_IDLE;
      load_q   <= 1'b0;
      store_q  <= 1'b0;
      mask_q   <= '0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        // Both enables high is a store: the write enable wins.
        load_q   <= in_mem_r_en & ~in_mem_w_en;
        store_q  <= in_mem_w_en;
        mask_q   <= in_mem_mask;
        funct3_q <= in_funct3;
        addr_q   <= in_addr;
        wdata_q  <= in_wdata;
      end
    end
  end

  assign in_ready      = (state_q == LSU_IDLE);
  assign bus_req_valid = (state_q == LSU_REQ);
  assign bus_addr      = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_we        = store_q;
  assign bus_wstrb     = store_q ? strb_sh : 4'b0000;
  assign bus_wdata     = store_q ? wdata_sh : '0;
  assign out_valid     = (state_q == LSU_DONE);
  assign out_rdata     = rdata_q;
  assign out_err       = err_q;

endmodule

// File: doc/ysyx_23060075_lsu.md
# ysyx_23060075_lsu

Load/store unit sitting directly downstream of the control decoder: it consumes the decoder's `mem_r_en`, `mem_w_en`, `mem_mask` and `funct3` together with the ALU-computed address and store data. It runs one word-aligned transaction on the data-memory bus and returns lane-aligned, sign/zero-extended load data to writeback. Requests and results use valid/ready handshakes, and the block holds at most one request at a time.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; fixed at 32, so the byte-lane logic assumes 4 lanes.
- `clk` input 1: clock.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: request valid.
- `in_ready` output 1: block can accept a request.
- `in_mem_r_en` input 1: load request.
- `in_mem_w_en` input 1: store request.
- `in_mem_mask` input `MEM_MASK_WIDTH` (4): size mask, one of 0001 / 0011 / 1111.
- `in_funct3` input `FUNCT3_WIDTH` (3): load extension select.
- `in_addr` input `ADDR_W`: effective byte address.
- `in_wdata` input `DATA_W`: store data, low-aligned.
- `bus_req_valid` output 1: bus request valid.
- `bus_req_ready` input 1: bus accepts the request.
- `bus_addr` output `ADDR_W`: word address, `{in_addr[31:2],2'b00}`.
- `bus_we` output 1: write request.
- `bus_wstrb` output 4: byte strobes.
- `bus_wdata` output `DATA_W`: lane-shifted store data.
- `bus_rsp_valid` input 1: response valid.
- `bus_rsp_data` input `DATA_W`: raw read word.
- `bus_rsp_err` input 1: bus error.
- `out_valid` output 1: result valid.
- `out_ready` input 1: writeback accepts the result.
- `out_rdata` output `DATA_W`: extended load data; 0 for stores and non-memory requests.
- `out_err` output 1: bus error or misalignment.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. `in_ready` = (state == IDLE).
- **Accept.** `in_valid & in_ready` latches every `in_*` field into registers.
- **Non-memory request** (`r_en` = 0 and `w_en` = 0): go to DONE; no bus activity; `out_rdata` = 0.
- **Both enables high:** the request is treated as a store and no read is performed.
- **REQ state:**
  - `bus_req_valid` = 1; all `bus_*` fields come from the latched registers and stay stable while waiting.
  - `bus_req_ready` = 1 moves the FSM to WAIT.
- **Store lanes:**
  - `bus_wstrb = (mask << addr[1:0])[3:0]`.
  - `bus_wdata = wdata << 8*addr[1:0]`.
  - `bus_we` = 1.
- **Load lanes:** `bus_wstrb` = 0 and `bus_we` = 0.
- **WAIT state:**
  - `bus_rsp_valid` = 1 captures data and error, then moves to DONE.
  - Responses are ignored in every other state.
- **Load extension** (applied to `sh = rsp_data >> 8*addr[1:0]`):
  - funct3 000 → `sext(sh[7:0])`.
  - 001 → `sext(sh[15:0])`.
  - 010 → `sh`.
  - 100 → `zext(sh[7:0])`.
  - 101 → `zext(sh[15:0])`.
  - any other code → `sh`.
- **DONE state:**
  - `out_valid` = 1, with `out_rdata` and `out_err` held stable.
  - `out_ready` = 1 moves the FSM to IDLE.
- **Error:** `out_err` = captured `bus_rsp_err`. A store that receives an error still completes.

## Timing
- **Reset values:** state = IDLE, `in_ready` = 1, `bus_req_valid` = 0, `bus_we` = 0, `bus_wstrb` = 0, `bus_addr` = 0, `bus_wdata` = 0, `out_valid` = 0, `out_rdata` = 0, `out_err` = 0.
- **Memory request latency:**
  - Accept at cycle T; `bus_req_valid` goes high at T+1.
  - If `bus_req_ready` is high at T+1, the FSM enters WAIT at T+2.
  - If the response arrives at T+2, `out_valid` goes high at T+3, which is the minimum.
- **Non-memory request latency:** `out_valid` goes high at T+1.
- **Back-pressure:** after the `out` handshake the FSM is in IDLE the next cycle, so back-to-back requests are spaced by at least 1 cycle of IDLE.
- **Bus contract:** a response never arrives in the same cycle as its request acceptance.
- **Reset mid-operation:** outputs return to their reset values immediately. A late response arrives while the FSM is in IDLE and is dropped.

## Configuration
- Macro: `YSYX_23060075_LSU_ALIGN_CHECK_EN`.
- **Defined:**
  - A misaligned access (mask 1111 with `addr[1:0]` ≠ 0, or mask 0011 with `addr[0]` = 1) issues no bus request.
  - The FSM goes IDLE → DONE with `out_err` = 1 and `out_rdata` = 0.
- **Undefined:** there is no check; strobe bits shifted past lane 3 are dropped, and load bytes past lane 3 read as 0.

## Structure
- `config.vh` gains:
  - `ysyx_23060075_LSU_STATE_WIDTH` (2) and the four state encodings.
  - Load funct3 codes: LB, LH, LW, LBU, LHU.
  - `ysyx_23060075_MEM_MASK_WIDTH` reuse.
- Sub-module `ysyx_23060075_lsu_align`: purely combinational. Performs the store strobe/data shift and the load shift and extension. Instantiated once.

## Test plan
- **SW:** addr 0x8000_0004, wdata 0xDEADBEEF, mask 1111, bus ready immediately → `bus_addr` 0x8000_0004, `wstrb` 1111, `out_valid` at T+3, `out_rdata` 0.
- **SB:** addr 0x8000_0003, wdata 0x0000_00A5, mask 0001 → `wstrb` 1000, `bus_wdata` 0xA500_0000.
- **LB / LBU:** addr 0x...2, `rsp_data` 0x1280_5634 → LB gives 0xFFFF_FF80; LBU gives 0x0000_0080.
- **LH with stalls:** addr 0x...2, `bus_req_ready` low for 3 cycles, response after 2 more, `out_ready` low for 2 cycles → bus fields stable throughout, `out_rdata` = `sext(0x1280)` = 0x0000_1280 held until handshake.
- **Bus error and reset:**
  - `bus_rsp_err` = 1 on a LW → `out_err` = 1.
  - Assert `rst` while in WAIT → `bus_req_valid`/`out_valid` go 0 at once; a later response is ignored and `in_ready` = 1.
- **Misaligned LW at 0x...1:**
  - With `YSYX_23060075_LSU_ALIGN_CHECK_EN` defined → no `bus_req_valid`; `out_err` = 1 at T+1.
  - Without the macro → a bus read is issued to 0x...0.
